// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its next-PC logic.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational PC+4 adder and redirect-target priority mux (jr/jalr > j/jal > branch).
module fetch_next_pc (
    input  logic [31:0] pc_f,
    input  logic        jadition,
    input  logic        jump,
    input  logic [31:0] rs,
    input  logic [3:0]  pc4_hi,
    input  logic [25:0] instr_index,
    input  logic [31:0] pcbranch,
    output logic [31:0] pc_plus4,
    output logic [31:0] target
);

    assign pc_plus4 = pc_f + 32'd4;

    always_comb begin
        target = pcbranch;
        if (jadition) begin
            target = rs;
        end else if (jump) begin
            target = {pc4_hi, instr_index, 2'b00};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register; req/ack instruction memory, stall and redirect handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        pcsrc_d,
    input  logic [31:0] pcbranch_d,
    input  logic        jump_d,
    input  logic        jadition_d,
    input  logic [31:0] rs_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic [5:0]  op_d,
    output logic [5:0]  funct_d
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  instr_reg;
    logic [31:0]  pcplus4_reg;
    logic         valid_reg;
    logic         req_reg;
    logic [31:0]  hold_instr_reg;
    logic [31:0]  hold_pc4_reg;
    logic [31:0]  pending_pc_reg;

    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic         redirect;
    logic         ack;

    fetch_next_pc u_next_pc (
        .pc_f        (pc_reg),
        .jadition    (jadition_d),
        .jump        (jump_d),
        .rs          (rs_d),
        .pc4_hi      (pcplus4_reg[31:28]),
        .instr_index (instr_reg[25:0]),
        .pcbranch    (pcbranch_d),
        .pc_plus4    (pc_plus4),
        .target      (target)
    );

    assign redirect = valid_reg & ~stall_d & (jadition_d | jump_d | pcsrc_d);
    // An ack only counts against a request we actually have outstanding.
    assign ack      = imem_ack & req_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            instr_reg      <= NOP_INSTR;
            pcplus4_reg    <= 32'd0;
            valid_reg      <= 1'b0;
            req_reg        <= 1'b0;
            hold_instr_reg <= NOP_INSTR;
            hold_pc4_reg   <= 32'd0;
            pending_pc_reg <= RESET_PC;
        end else begin
            req_reg <= 1'b1;
            case (state_reg)
                RUN: begin
                    if (redirect) begin
                        instr_reg <= NOP_INSTR;
                        valid_reg <= 1'b0;
                        if (ack) begin
                            pc_reg <= target;
                        end else begin
                            pending_pc_reg <= target;
                            state_reg      <= DRAIN;
                        end
                    end else if (stall_d) begin
                        if (ack) begin
                            hold_instr_reg <= imem_rdata;
                            hold_pc4_reg   <= pc_plus4;
                            pc_reg         <= pc_plus4;
                            req_reg        <= 1'b0;
                            state_reg      <= HOLD;
                        end
                    end else if (ack) begin
                        instr_reg   <= imem_rdata;
                        pcplus4_reg <= pc_plus4;
                        valid_reg   <= 1'b1;
                        pc_reg      <= pc_plus4;
                    end else begin
                        instr_reg <= NOP_INSTR;
                        valid_reg <= 1'b0;
                    end
                end
                HOLD: begin
                    if (stall_d) begin
                        req_reg <= 1'b0;
                    end else begin
                        state_reg <= RUN;
                        if (redirect) begin
                            pc_reg    <= target;
                            instr_reg <= NOP_INSTR;
                            valid_reg <= 1'b0;
                        end else begin
                            instr_reg   <= hold_instr_reg;
                            pcplus4_reg <= hold_pc4_reg;
                            valid_reg   <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The in-flight word belongs to the squashed path; drop it and jump.
                    if (ack) begin
                        pc_reg    <= pending_pc_reg;
                        state_reg <= RUN;
                    end
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign imem_req  = req_reg;
    assign imem_addr = pc_reg;
    assign instr_d   = instr_reg;
    assign pcplus4_d = pcplus4_reg;
    assign valid_d   = valid_reg;
    assign op_d      = instr_reg[OP_MSB:OP_LSB];
    assign funct_d   = instr_reg[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: one line per check, one summary line.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_d;
    logic        pcsrc_d;
    logic [31:0] pcbranch_d;
    logic        jump_d;
    logic        jadition_d;
    logic [31:0] rs_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic [5:0]  op_d;
    logic [5:0]  funct_d;

    int n_checks;
    int n_errors;

    logic [31:0] data_vec [4];

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall_d    (stall_d),
        .pcsrc_d    (pcsrc_d),
        .pcbranch_d (pcbranch_d),
        .jump_d     (jump_d),
        .jadition_d (jadition_d),
        .rs_d       (rs_d),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_d    (instr_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d),
        .op_d       (op_d),
        .funct_d    (funct_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_d    = 1'b0;
        pcsrc_d    = 1'b0;
        pcbranch_d = 32'd0;
        jump_d     = 1'b0;
        jadition_d = 1'b0;
        rs_d       = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
    endtask

    // Reset for one cycle, then one idle cycle while imem_req rises.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        data_vec[0] = 32'h2001_0001;
        data_vec[1] = 32'h2002_0002;
        data_vec[2] = 32'h0022_1820;
        data_vec[3] = 32'hAC03_0004;
        clear_inputs();

        // Reset values
        reset = 1'b1;
        tick();
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, valid_d}, 32'd0);
        check("rst_instr", instr_d, 32'h0);
        check("rst_pc4",   pcplus4_d, 32'h0);
        reset = 1'b0;
        tick();
        check("req_rise", {31'd0, imem_req}, 32'd1);

        // Back-to-back acks
        for (int i = 0; i < 4; i++) begin
            check($sformatf("seq_addr%0d", i), imem_addr, 32'(4 * i));
            imem_ack   = 1'b1;
            imem_rdata = data_vec[i];
            tick();
            check($sformatf("seq_instr%0d", i), instr_d, data_vec[i]);
            check($sformatf("seq_pc4_%0d", i), pcplus4_d, 32'(4 * (i + 1)));
            check($sformatf("seq_valid%0d", i), {31'd0, valid_d}, 32'd1);
        end

        // Ack coinciding with a 2-cycle stall (pc = 0x10)
        stall_d    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA_0010;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("stall1_instr", instr_d, data_vec[3]);
        check("stall1_req",   {31'd0, imem_req}, 32'd0);
        tick();
        check("stall2_instr", instr_d, data_vec[3]);
        check("stall2_req",   {31'd0, imem_req}, 32'd0);
        stall_d = 1'b0;
        tick();
        check("unstall_instr", instr_d, 32'hAAAA_0010);
        check("unstall_pc4",   pcplus4_d, 32'h14);
        check("unstall_valid", {31'd0, valid_d}, 32'd1);
        check("unstall_addr",  imem_addr, 32'h14);
        check("unstall_req",   {31'd0, imem_req}, 32'd1);

        // Jump: fetch 0 (nop) and 4 (j 0x40), then redirect
        do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0;
        tick();
        imem_rdata = 32'h0800_0010;
        tick();
        check("j_instr", instr_d, 32'h0800_0010);
        check("j_pc4",   pcplus4_d, 32'h8);
        check("j_op",    {26'd0, op_d}, 32'h2);
        check("j_funct", {26'd0, funct_d}, 32'h10);
        jump_d     = 1'b1;
        imem_rdata = 32'hBAD0_0008;
        tick();
        jump_d = 1'b0;
        check("j_addr",  imem_addr, 32'h40);
        check("j_valid", {31'd0, valid_d}, 32'd0);
        check("j_squash", instr_d, 32'h0);
        imem_rdata = 32'h1111_0040;
        tick();
        check("j_next_instr", instr_d, 32'h1111_0040);
        check("j_next_pc4",   pcplus4_d, 32'h44);
        check("j_next_valid", {31'd0, valid_d}, 32'd1);

        // Branch taken while the next fetch (0x44) is still outstanding
        imem_ack   = 1'b0;
        pcsrc_d    = 1'b1;
        pcbranch_d = 32'h100;
        tick();
        pcsrc_d    = 1'b0;
        pcbranch_d = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("br_wait_addr%0d", i), imem_addr, 32'h44);
            check($sformatf("br_wait_valid%0d", i), {31'd0, valid_d}, 32'd0);
            if (i < 2) tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("br_addr",   imem_addr, 32'h100);
        check("br_drop",   instr_d, 32'h0);
        check("br_valid",  {31'd0, valid_d}, 32'd0);
        imem_rdata = 32'h2222_0100;
        tick();
        check("br_instr",  instr_d, 32'h2222_0100);
        check("br_pc4",    pcplus4_d, 32'h104);
        check("br_after",  imem_addr, 32'h104);

        // All redirects asserted: first under stall (ignored), then released
        imem_ack   = 1'b0;
        jadition_d = 1'b1;
        jump_d     = 1'b1;
        pcsrc_d    = 1'b1;
        rs_d       = 32'h200;
        pcbranch_d = 32'h100;
        stall_d    = 1'b1;
        tick();
        check("pri_stall_addr",  imem_addr, 32'h104);
        check("pri_stall_instr", instr_d, 32'h2222_0100);
        check("pri_stall_valid", {31'd0, valid_d}, 32'd1);
        check("pri_stall_pc4",   pcplus4_d, 32'h104);
        stall_d  = 1'b0;
        imem_ack = 1'b1;
        tick();
        clear_inputs();
        check("pri_addr",  imem_addr, 32'h200);
        check("pri_valid", {31'd0, valid_d}, 32'd0);

        // Reset while draining
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_0200;
        tick();
        check("dr_instr", instr_d, 32'h3333_0200);
        imem_ack   = 1'b0;
        pcsrc_d    = 1'b1;
        pcbranch_d = 32'h300;
        tick();
        pcsrc_d = 1'b0;
        check("dr_addr", imem_addr, 32'h204);
        reset = 1'b1;
        tick();
        check("dr_rst_addr",  imem_addr, 32'h0);
        check("dr_rst_valid", {31'd0, valid_d}, 32'd0);
        check("dr_rst_req",   {31'd0, imem_req}, 32'd0);
        reset = 1'b0;
        tick();

        // PC+4 wrap at the top of the address space
        imem_ack   = 1'b1;
        imem_rdata = 32'h0;
        tick();
        jadition_d = 1'b1;
        rs_d       = 32'hFFFF_FFFC;
        tick();
        jadition_d = 1'b0;
        check("wrap_top", imem_addr, 32'hFFFF_FFFC);
        imem_rdata = 32'h4444_FFFC;
        tick();
        check("wrap_addr",  imem_addr, 32'h0);
        check("wrap_instr", instr_d, 32'h4444_FFFC);
        check("wrap_pc4",   pcplus4_d, 32'h0);
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
